// File: rtl/rename_reg_file.sv
// Architectural register file plus register alias table with in-order multi-port commit.
// Define RF_COMMIT_BYPASS_EN to forward same-cycle commit values to operand reads.
module rename_reg_file #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int ROB_W        = 4,
    parameter int READ_PORTS   = 2,
    parameter int COMMIT_PORTS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic [READ_PORTS*REG_AW-1:0]   rd_addr,
    output logic [READ_PORTS*XLEN-1:0]     rd_val,
    output logic [READ_PORTS*ROB_W-1:0]    rd_tag,
    output logic [READ_PORTS-1:0]          rd_ready,
    input  logic [COMMIT_PORTS-1:0]        cm_valid,
    input  logic [COMMIT_PORTS*REG_AW-1:0] cm_regid,
    input  logic [COMMIT_PORTS*XLEN-1:0]   cm_value,
    input  logic [COMMIT_PORTS*ROB_W-1:0]  cm_robid,
    input  logic                           rn_valid,
    input  logic [REG_AW-1:0]              rn_regid,
    input  logic [ROB_W-1:0]               rn_robid,
    input  logic                           flush,
    output logic [REG_AW:0]                busy_cnt
);
    localparam int NUM_REGS = 1 << REG_AW;

    logic [XLEN-1:0]     val_q [NUM_REGS];
    logic [XLEN-1:0]     val_d [NUM_REGS];
    logic [ROB_W-1:0]    tag_q [NUM_REGS];
    logic [ROB_W-1:0]    tag_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [REG_AW:0]     busy_cnt_q, busy_cnt_d;

    always_comb begin : next_state
        logic [REG_AW-1:0] reg_idx;
        // NOTE: every comb output gets a default first so no path can infer a latch.
        reg_idx    = '0;
        val_d      = val_q;
        tag_d      = tag_q;
        busy_d     = busy_q;
        busy_cnt_d = '0;

        if (rdy) begin
            // Commit: value always lands; busy clears only when the retiring tag is the live mapping.
            for (int c = 0; c < COMMIT_PORTS; c++) begin
                reg_idx = cm_regid[c*REG_AW +: REG_AW];
                if (cm_valid[c] && reg_idx != '0) begin
                    val_d[reg_idx] = cm_value[c*XLEN +: XLEN];
                    if (busy_q[reg_idx] && tag_q[reg_idx] == cm_robid[c*ROB_W +: ROB_W])
                        busy_d[reg_idx] = 1'b0;
                end
            end

            if (rn_valid && rn_regid != '0) begin
                tag_d[rn_regid]  = rn_robid;
                busy_d[rn_regid] = 1'b1;
            end

            if (flush) begin
                busy_d = '0;
                for (int i = 0; i < NUM_REGS; i++)
                    tag_d[i] = '0;
            end
        end

        for (int i = 0; i < NUM_REGS; i++)
            busy_cnt_d = busy_cnt_d + {{REG_AW{1'b0}}, busy_d[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the file is built from flops, so every entry is cleared; a RAM-based file could not be.
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge next-state together.
            val_q      <= val_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Reads see only registered state, so a same-cycle rename is invisible to dispatch.
    always_comb begin : read_ports
        logic [REG_AW-1:0] addr;
        addr     = '0;
        rd_val   = '0;
        rd_tag   = '0;
        rd_ready = '1;
        for (int p = 0; p < READ_PORTS; p++) begin
            addr = rd_addr[p*REG_AW +: REG_AW];
            if (addr != '0) begin
                rd_val[p*XLEN +: XLEN]    = val_q[addr];
                rd_tag[p*ROB_W +: ROB_W]  = tag_q[addr];
                rd_ready[p]               = !busy_q[addr];
`ifdef RF_COMMIT_BYPASS_EN
                for (int c = 0; c < COMMIT_PORTS; c++) begin
                    if (busy_q[addr] && cm_valid[c] &&
                        cm_robid[c*ROB_W +: ROB_W] == tag_q[addr]) begin
                        rd_val[p*XLEN +: XLEN] = cm_value[c*XLEN +: XLEN];
                        rd_ready[p]            = 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: directed scenarios then random traffic,
// scored against a per-register reference model through an expectation queue.
module tb_rename_reg_file;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int ROB_W  = 4;
    localparam int RP     = 2;
    localparam int CP     = 2;
    localparam int NR     = 1 << REG_AW;
    localparam int NT     = 1 << ROB_W;

    logic                   clk;
    logic                   rst;
    logic                   rdy;
    logic [RP*REG_AW-1:0]   rd_addr;
    logic [RP*XLEN-1:0]     rd_val;
    logic [RP*ROB_W-1:0]    rd_tag;
    logic [RP-1:0]          rd_ready;
    logic [CP-1:0]          cm_valid;
    logic [CP*REG_AW-1:0]   cm_regid;
    logic [CP*XLEN-1:0]     cm_value;
    logic [CP*ROB_W-1:0]    cm_robid;
    logic                   rn_valid;
    logic [REG_AW-1:0]      rn_regid;
    logic [ROB_W-1:0]       rn_robid;
    logic                   flush;
    logic [REG_AW:0]        busy_cnt;

    rename_reg_file #(
        .XLEN(XLEN), .REG_AW(REG_AW), .ROB_W(ROB_W),
        .READ_PORTS(RP), .COMMIT_PORTS(CP)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_addr(rd_addr), .rd_val(rd_val), .rd_tag(rd_tag), .rd_ready(rd_ready),
        .cm_valid(cm_valid), .cm_regid(cm_regid), .cm_value(cm_value), .cm_robid(cm_robid),
        .rn_valid(rn_valid), .rn_regid(rn_regid), .rn_robid(rn_robid),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what each architectural register holds and which ROB entry will produce it.
    logic [XLEN-1:0]  m_val  [NR];
    logic [ROB_W-1:0] m_tag  [NR];
    bit               m_busy [NR];
    bit               model_valid = 1'b0;

    typedef struct {
        logic [RP*XLEN-1:0]  val;
        logic [RP*ROB_W-1:0] tag;
        logic [RP-1:0]       ready;
        logic [REG_AW:0]     cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_busy_count();
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Expected operand for one read address given the current model and this cycle's commits.
    task automatic model_read(input int a, output logic [XLEN-1:0] v,
                              output logic [ROB_W-1:0] t, output logic rd);
        v  = m_val[a];
        t  = m_tag[a];
        rd = !m_busy[a];
        if (a == 0) begin
            v = '0; t = '0; rd = 1'b1;
        end
`ifdef RF_COMMIT_BYPASS_EN
        else if (m_busy[a]) begin
            for (int c = 0; c < CP; c++)
                if (cm_valid[c] && cm_robid[c*ROB_W +: ROB_W] == m_tag[a]) begin
                    v  = cm_value[c*XLEN +: XLEN];
                    rd = 1'b1;
                end
        end
`endif
    endtask

    // Each register's next state depends only on its own old state and this cycle's requests.
    task automatic model_update();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_val[r] = '0; m_tag[r] = '0; m_busy[r] = 1'b0;
            end
            model_valid = 1'b1;
            return;
        end
        if (!rdy) return;
        for (int r = 1; r < NR; r++) begin
            bit retired = 1'b0;
            bit renamed = rn_valid && int'(rn_regid) == r;
            for (int c = 0; c < CP; c++)
                if (cm_valid[c] && int'(cm_regid[c*REG_AW +: REG_AW]) == r) begin
                    m_val[r] = cm_value[c*XLEN +: XLEN];
                    if (m_busy[r] && m_tag[r] == cm_robid[c*ROB_W +: ROB_W]) retired = 1'b1;
                end
            if (flush) begin
                m_busy[r] = 1'b0; m_tag[r] = '0;
            end else if (renamed) begin
                m_busy[r] = 1'b1; m_tag[r] = rn_robid;
            end else if (retired) begin
                m_busy[r] = 1'b0;
            end
        end
    endtask

    // Push this cycle's expectations, advance the model, then move to the next cycle.
    task automatic step();
        exp_t e;
        if (model_valid) begin
            for (int p = 0; p < RP; p++) begin
                logic [XLEN-1:0]  v;
                logic [ROB_W-1:0] t;
                logic             rd;
                model_read(int'(rd_addr[p*REG_AW +: REG_AW]), v, t, rd);
                e.val[p*XLEN +: XLEN]   = v;
                e.tag[p*ROB_W +: ROB_W] = t;
                e.ready[p]              = rd;
            end
            e.cnt = (REG_AW+1)'(model_busy_count());
            exp_q.push_back(e);
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; rd_addr = '0;
        cm_valid = '0; cm_regid = '0; cm_value = '0; cm_robid = '0;
        rn_valid = 1'b0; rn_regid = '0; rn_robid = '0;
    endtask

    task automatic tick();
        step();
        idle();
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*REG_AW +: REG_AW] = REG_AW'(a);
    endtask

    task automatic set_cm(input int c, input int r, input logic [XLEN-1:0] v, input int t);
        cm_valid[c]                   = 1'b1;
        cm_regid[c*REG_AW +: REG_AW]  = REG_AW'(r);
        cm_value[c*XLEN +: XLEN]      = v;
        cm_robid[c*ROB_W +: ROB_W]    = ROB_W'(t);
    endtask

    task automatic set_rn(input int r, input int t);
        rn_valid = 1'b1;
        rn_regid = REG_AW'(r);
        rn_robid = ROB_W'(t);
    endtask

    function automatic int pick_busy_reg();
        int list[$];
        for (int r = 1; r < NR; r++) if (m_busy[r]) list.push_back(r);
        if (list.size() == 0) return 0;
        return list[$urandom_range(0, list.size() - 1)];
    endfunction

    task automatic randomize_inputs();
        rst   = ($urandom_range(0, 999) == 0);
        rdy   = ($urandom_range(0, 9) != 0);
        flush = ($urandom_range(0, 29) == 0);
        for (int p = 0; p < RP; p++) begin
            int b = pick_busy_reg();
            set_rd(p, ($urandom_range(0, 1) == 1 && b != 0) ? b : int'($urandom_range(0, NR - 1)));
        end
        cm_valid = '0;
        for (int c = 0; c < CP; c++) begin
            if ($urandom_range(0, 9) < 6) begin
                int b = pick_busy_reg();
                if (b != 0 && $urandom_range(0, 2) != 0)
                    set_cm(c, b, $urandom, int'(m_tag[b]));
                else
                    set_cm(c, int'($urandom_range(0, NR - 1)), $urandom, int'($urandom_range(0, NT - 1)));
            end
        end
        // Two ports never retire the same ROB entry in one cycle.
        if (cm_valid[0] && cm_valid[1] && cm_robid[0 +: ROB_W] == cm_robid[ROB_W +: ROB_W])
            cm_robid[ROB_W +: ROB_W] = cm_robid[0 +: ROB_W] + 1'b1;
        rn_valid = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
            int free[$];
            for (int t = 0; t < NT; t++) begin
                bit used = 1'b0;
                for (int r = 1; r < NR; r++) if (m_busy[r] && int'(m_tag[r]) == t) used = 1'b1;
                if (!used) free.push_back(t);
            end
            if (free.size() > 0)
                set_rn(int'($urandom_range(0, NR - 1)), free[$urandom_range(0, free.size() - 1)]);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle's expectation is scored at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int p = 0; p < RP; p++) begin
                check($sformatf("rd_val[%0d]", p),   rd_val[p*XLEN +: XLEN],            mon_e.val[p*XLEN +: XLEN]);
                check($sformatf("rd_tag[%0d]", p),   XLEN'(rd_tag[p*ROB_W +: ROB_W]),   XLEN'(mon_e.tag[p*ROB_W +: ROB_W]));
                check($sformatf("rd_ready[%0d]", p), XLEN'(rd_ready[p]),                XLEN'(mon_e.ready[p]));
            end
            check("busy_cnt", XLEN'(busy_cnt), XLEN'(mon_e.cnt));
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;

        // Reset state through both ports, including the hardwired zero register.
        set_rd(0, 5); set_rd(1, 0); tick();

        // Rename then a read that races the retiring commit on port 1.
        set_rn(3, 7); tick();
        set_rd(0, 3); set_cm(1, 3, 32'hDEAD, 7); tick();
        set_rd(0, 3); tick();

        // Stale commit writes the value but leaves the newer mapping in place.
        set_rn(4, 2); tick();
        set_rn(4, 5); tick();
        set_cm(0, 4, 32'h11, 2); set_rd(1, 4); tick();
        set_rd(1, 4); tick();
        set_cm(0, 4, 32'h22, 5); tick();
        set_rd(1, 4); tick();

        // Two commits to one register: the younger port wins.
        set_rn(6, 2); tick();
        set_cm(0, 6, 32'hA, 1); set_cm(1, 6, 32'hB, 2); tick();
        set_rd(0, 6); tick();

        // Rename beats a same-cycle retire; flush beats a same-cycle rename.
        set_rn(8, 3); tick();
        set_cm(0, 8, 32'h88, 3); set_rn(8, 9); tick();
        set_rd(0, 8); tick();
        flush = 1'b1; set_rn(9, 10); tick();
        set_rd(0, 8); set_rd(1, 9); tick();

        // Stalled cycle holds everything; then x0 ignores rename and commit.
        set_rn(10, 4); tick();
        rdy = 1'b0; set_cm(0, 10, 32'h55, 4); set_rn(11, 6); flush = 1'b1; tick();
        set_rd(0, 10); set_rd(1, 11); tick();
        set_rn(0, 1); set_cm(0, 0, 32'hFF, 1); tick();
        set_rd(0, 0); set_rd(1, 6); tick();

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end
        rst = 1'b0;
        idle();

        repeat (2) @(negedge clk);
        check("expectations_drained", XLEN'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
Architectural register file plus register alias table (RAT) for the Tomasulo/ROB core, generalised to READ_PORTS read ports and COMMIT_PORTS in-order commit ports. It sits between dispatch (which reads operands and renames) and ROB commit (which retires values). On a mispredict flush it clears all renames. Architectural values are preserved across the flush.

Parameters:
XLEN, 32, data width
REG_AW, 5, register index width; NUM_REGS = 1<<REG_AW
ROB_W, 4, ROB tag width
READ_PORTS, 2, number of operand read ports
COMMIT_PORTS, 2, commits per cycle; port 0 is oldest

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = hold all state
rd_addr  in  READ_PORTS*REG_AW  read indices, port p at [p*REG_AW +: REG_AW]
rd_val  out  READ_PORTS*XLEN  operand value
rd_tag  out  READ_PORTS*ROB_W  producing ROB tag, valid when !rd_ready
rd_ready  out  READ_PORTS  1 = rd_val is final
cm_valid  in  COMMIT_PORTS  commit strobes
cm_regid  in  COMMIT_PORTS*REG_AW  destination register
cm_value  in  COMMIT_PORTS*XLEN  result value
cm_robid  in  COMMIT_PORTS*ROB_W  retiring ROB tag
rn_valid  in  1  rename request from dispatch
rn_regid  in  REG_AW  destination being renamed
rn_robid  in  ROB_W  new producer tag
flush  in  1  mispredict: clear all renames
busy_cnt  out  REG_AW+1  number of renamed registers (registered)

Behaviour:
- State per register r: val[r], tag[r], busy[r].
- Reset: all val=0, tag=0, busy=0, busy_cnt=0. Combinational outputs after reset: rd_val=0, rd_tag=0, rd_ready=1 for every port.
- rdy=0: no state update. Combinational outputs still track inputs.
- Register 0:
  - reads always return val=0, ready=1, tag=0.
  - commits to r0 are ignored.
  - renames of r0 are ignored.
- Reads are combinational, zero latency. For port p with a=rd_addr[p]:
  - !busy[a]: val[a], ready=1.
  - busy[a] and some valid commit port c has cm_robid[c]==tag[a]: cm_value[c], ready=1 (commit bypass; see Optional Feature).
  - otherwise: val[a], ready=0, rd_tag=tag[a].
  - rd_tag always equals tag[a].
- Reads never see a same-cycle rename. Dispatch reads the old mapping before its own rename.
- Commit (per cycle, ports applied in order 0..COMMIT_PORTS-1):
  - val[cm_regid] <= cm_value whether or not the tag matches. Later port wins on same regid.
  - busy cleared only if busy and tag[cm_regid]==cm_robid.
- Rename: if rn_valid && rn_regid!=0, then tag<=rn_robid and busy<=1.
  - Rename beats a same-cycle commit clear on the same register.
- Flush: all busy<=0 and tag<=0. Flush overrides a same-cycle rename. Same-cycle commits still write val.
- busy_cnt is updated at the clock edge to popcount of next-state busy. Range 0..NUM_REGS-1.
- Tags are unique among in-flight entries. Two commit ports never carry the same robid in one cycle; behaviour under such input is undefined.

Optional Feature:
Macro RF_COMMIT_BYPASS_EN.
- Defined: same-cycle commit forwarding to reads, as in Behaviour.
- Undefined: no forwarding. A read of a busy register gives ready=0 and tag=tag[a] even when that tag commits this cycle; the read resolves via the CDB or on the next cycle. This shortens the read critical path.

Test Plan:
- Reset, then read x5 and x0 -> rd_val=0, rd_ready=1, rd_tag=0; busy_cnt=0.
- Rename x3->tag 7. Next cycle read x3 -> ready=0, rd_tag=7. Same cycle commit port1 {x3, 0xDEAD, tag 7}: with the macro, rd_val=0xDEAD, ready=1; without it, ready=0. Following cycle -> val 0xDEAD, ready=1, busy_cnt=0.
- Rename x4->tag 2, then x4->tag 5. Commit {x4, 0x11, tag 2} -> val[x4]=0x11, x4 still busy with tag 5. Commit {x4, 0x22, tag 5} -> busy cleared, val=0x22.
- Same cycle: port0 {x6, 0xA, tag1}, port1 {x6, 0xB, tag2}, tag[x6]=2 -> val=0xB, x6 not busy.
- Same cycle: commit clears x8 (tag 3) and rename x8->tag 9 -> x8 busy, tag 9. Then flush with rn_valid on x9 -> all busy=0, x9 not renamed, busy_cnt=0, committed values intact.
- rdy=0 with commit, rename and flush asserted -> no state change. Rename and commit of x0 -> x0 reads 0, ready=1.
